bf16_adder: RTL and testbench

- Single-cycle-latency BFloat16 (1 sign, 8 exponent bits with bias 127, 7 mantissa bits) floating-point adder.
- Computes A + B with IEEE-754-style round-to-nearest-even.
- Handles zero, infinity and NaN. Subnormals are flushed to zero.
- Used as the addition primitive of the BF16 arithmetic datapath. Result is registered on the output.

---
 rtl/bf16_adder.sv | 138 +++++++++++++
 tb/tb_bf16_adder.sv | 116 +++++++++++
 2 files changed

// File: rtl/bf16_adder.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_adder
//  Description : BFloat16 adder, round-to-nearest-even, DAZ/FTZ, with a
//                single registered output stage (1-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module bf16_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic       sa_i,
    input  logic [7:0] ea_i,
    input  logic [6:0] ma_i,
    input  logic       sb_i,
    input  logic [7:0] eb_i,
    input  logic [6:0] mb_i,
    output logic       s_o,
    output logic [7:0] e_o,
    output logic [6:0] m_o
);

    localparam logic [7:0] c_exp_max = 8'hFF;
    localparam logic [6:0] c_qnan_m  = 7'h40;

    // Operand classification
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    assign w_a_zero = (ea_i == 8'h00);
    assign w_b_zero = (eb_i == 8'h00);
    assign w_a_inf  = (ea_i == c_exp_max) && (ma_i == 7'h00);
    assign w_b_inf  = (eb_i == c_exp_max) && (mb_i == 7'h00);
    assign w_a_nan  = (ea_i == c_exp_max) && (ma_i != 7'h00);
    assign w_b_nan  = (eb_i == c_exp_max) && (mb_i != 7'h00);

    // Order operands by magnitude
    logic       w_a_ge, w_sl, w_ss;
    logic [7:0] w_el, w_es, w_diff;
    logic [6:0] w_ml, w_ms;
    assign w_a_ge = ({ea_i, ma_i} >= {eb_i, mb_i});
    assign w_sl   = w_a_ge ? sa_i : sb_i;
    assign w_ss   = w_a_ge ? sb_i : sa_i;
    assign w_el   = w_a_ge ? ea_i : eb_i;
    assign w_es   = w_a_ge ? eb_i : ea_i;
    assign w_ml   = w_a_ge ? ma_i : mb_i;
    assign w_ms   = w_a_ge ? mb_i : ma_i;
    assign w_diff = w_el - w_es;

    // Align smaller significand: {sig[7:0], guard, round, sticky}
    logic [17:0] w_ext, w_shifted;
    logic [10:0] w_l_al, w_s_al;
    assign w_ext     = {1'b1, w_ms, 10'b0};
    assign w_shifted = w_ext >> w_diff[3:0];
    assign w_s_al    = (w_diff >= 8'd10) ? 11'd1
                                         : {w_shifted[17:8], |w_shifted[7:0]};
    assign w_l_al    = {1'b1, w_ml, 3'b000};

    logic [11:0] w_sum;
    assign w_sum = (w_sl ^ w_ss) ? ({1'b0, w_l_al} - {1'b0, w_s_al})
                                 : ({1'b0, w_l_al} + {1'b0, w_s_al});

    logic [3:0] w_lzc;
    always_comb begin
        w_lzc = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (w_sum[i]) w_lzc = 4'(10 - i);
        end
    end

    logic        w_carry;
    logic [3:0]  w_lshift;
    logic [10:0] w_norm;
    assign w_carry  = w_sum[11];
    assign w_lshift = w_carry ? 4'd0 : w_lzc;
    assign w_norm   = w_carry ? {w_sum[11:2], w_sum[1] | w_sum[0]}
                              : (w_sum[10:0] << w_lzc);

    // Round to nearest, ties to even
    logic       w_round_up;
    logic [8:0] w_rnd;
    logic [6:0] w_mant;
    assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_rnd      = {1'b0, w_norm[10:3]} + {8'b0, w_round_up};
    assign w_mant     = w_rnd[8] ? w_rnd[7:1] : w_rnd[6:0];

    logic signed [9:0] w_exp;
    assign w_exp = $signed({2'b00, w_el}) + $signed({9'b0, w_carry})
                 - $signed({6'b0, w_lshift}) + $signed({9'b0, w_rnd[8]});

    logic       w_res_s;
    logic [7:0] w_res_e;
    logic [6:0] w_res_m;
    always_comb begin
        w_res_s = 1'b0;
        w_res_e = 8'h00;
        w_res_m = 7'h00;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (sa_i != sb_i))) begin
            w_res_e = c_exp_max;
            w_res_m = c_qnan_m;
        end else if (w_a_inf || w_b_inf) begin
            w_res_s = w_a_inf ? sa_i : sb_i;
            w_res_e = c_exp_max;
        end else if (w_a_zero && w_b_zero) begin
            w_res_s = sa_i & sb_i;
        end else if (w_a_zero) begin
            w_res_s = sb_i;
            w_res_e = eb_i;
            w_res_m = mb_i;
        end else if (w_b_zero) begin
            w_res_s = sa_i;
            w_res_e = ea_i;
            w_res_m = ma_i;
        end else if (w_sum == 12'd0) begin
            w_res_s = 1'b0;
        end else if (w_exp >= 10'sd255) begin
            w_res_s = w_sl;
            w_res_e = c_exp_max;
        end else if (w_exp <= 10'sd0) begin
            w_res_s = w_sl;
        end else begin
            w_res_s = w_sl;
            w_res_e = w_exp[7:0];
            w_res_m = w_mant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_o <= 1'b0;
            e_o <= 8'h00;
            m_o <= 7'h00;
        end else begin
            s_o <= w_res_s;
            e_o <= w_res_e;
            m_o <= w_res_m;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bf16_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bf16_adder
//  Description : Scoreboard bench for bf16_adder using directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bf16_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sa_i, sb_i, s_o;
    logic [7:0] ea_i, eb_i, e_o;
    logic [6:0] ma_i, mb_i, m_o;

    bf16_adder dut (
        .clk  (clk),
        .rst  (rst),
        .sa_i (sa_i),
        .ea_i (ea_i),
        .ma_i (ma_i),
        .sb_i (sb_i),
        .eb_i (eb_i),
        .mb_i (mb_i),
        .s_o  (s_o),
        .e_o  (e_o),
        .m_o  (m_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          cyc;
        int          idx;
    } exp_t;

    exp_t q_exp[$];
    int   r_cyc   = 0;
    int   n_check = 0;
    int   n_err   = 0;

    always @(posedge clk) r_cyc <= r_cyc + 1;

    // Monitor: each expectation is due at the negedge after its capture edge
    always @(negedge clk) begin
        if (q_exp.size() > 0 && q_exp[0].cyc < r_cyc) begin
            exp_t e;
            e = q_exp.pop_front();
            n_check++;
            if ({s_o, e_o, m_o} !== e.val) begin
                n_err++;
                $display("FAIL vec%0d: got %h expected %h", e.idx, {s_o, e_o, m_o}, e.val);
            end
        end
    end

    // Vectors are raw bf16 bit patterns {s, e[7:0], m[6:0]}
    localparam int c_nvec = 22;
    logic [15:0] c_va  [c_nvec] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h8000,
                                    16'h3F80, 16'h3F80, 16'h3FC0, 16'h3F80, 16'h3F81,
                                    16'h7F7F, 16'h7F80, 16'h7F81, 16'h0001, 16'h0080,
                                    16'h3F80, 16'hFF80, 16'h4000, 16'h3F80, 16'h3F80,
                                    16'h3F80, 16'h3B80};
    logic [15:0] c_vb  [c_nvec] = '{16'h0000, 16'h8000, 16'h8000, 16'h3F80, 16'h3F80,
                                    16'h3F80, 16'hBF80, 16'h3F00, 16'h3B80, 16'h3B80,
                                    16'h7F7F, 16'hFF80, 16'h3F80, 16'h3F80, 16'h8081,
                                    16'h3B81, 16'h3F80, 16'hBF80, 16'hBFC0, 16'h3380,
                                    16'hB380, 16'h3F81};
    logic [15:0] c_vr  [c_nvec] = '{16'h0000, 16'h0000, 16'h8000, 16'h3F80, 16'h3F80,
                                    16'h4000, 16'h0000, 16'h4000, 16'h3F80, 16'h3F82,
                                    16'h7F80, 16'h7FC0, 16'h7FC0, 16'h3F80, 16'h8000,
                                    16'h3F81, 16'hFF80, 16'h3F80, 16'hBF00, 16'h3F80,
                                    16'h3F80, 16'h3F82};

    task automatic drive(input logic [15:0] a, input logic [15:0] b);
        {sa_i, ea_i, ma_i} = a;
        {sb_i, eb_i, mb_i} = b;
    endtask

    initial begin
        int wait_cnt;
        rst = 1'b1;
        drive(16'h3F80, 16'h3F80);
        @(posedge clk);
        // Reset dominates non-zero operands
        for (int i = 0; i < 2; i++) begin
            #1;
            drive(16'h3FC0, 16'h4000);
            q_exp.push_back('{val: 16'h0000, cyc: r_cyc, idx: 100 + i});
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        // Back-to-back: one new pair every cycle
        for (int i = 0; i < c_nvec; i++) begin
            drive(c_va[i], c_vb[i]);
            q_exp.push_back('{val: c_vr[i], cyc: r_cyc, idx: i});
            @(posedge clk);
            #1;
        end
        wait_cnt = 0;
        while (q_exp.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (q_exp.size() > 0) begin
            n_check++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0 pending", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_check);
        $finish;
    end

endmodule
`default_nettype wire
